// File: rtl/uop_expander.sv
// Micro-op expansion queue: splits two-uop instructions into first/second uops,
// buffers them in a circular queue and presents pair-aligned output groups.
module uop_expander #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [IN_WIDTH-1:0]       in_valid,
    input  logic [IN_WIDTH*32-1:0]    in_pc,
    input  logic [IN_WIDTH*32-1:0]    in_inst,
    input  logic [IN_WIDTH-1:0]       in_ex,
    output logic                      in_ready,
    output logic [OUT_WIDTH-1:0]      out_valid,
    output logic [OUT_WIDTH*32-1:0]   out_pc,
    output logic [OUT_WIDTH*32-1:0]   out_inst,
    output logic [OUT_WIDTH-1:0]      out_ex,
    output logic [OUT_WIDTH-1:0]      out_is_inst2,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PW    = $clog2(DEPTH);
    localparam int SLOTS = 2 * IN_WIDTH;

    function automatic logic is_two_uop(input logic [5:0] op, input logic [5:0] fn);
        return ((op == 6'h00) && (fn >= 6'h18) && (fn <= 6'h1B)) ||
               ((op == 6'h1C) && ((fn == 6'h00) || (fn == 6'h01) || (fn == 6'h02) ||
                                  (fn == 6'h04) || (fn == 6'h05)));
    endfunction

    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_inst [DEPTH];
    logic [DEPTH-1:0] r_ex;
    logic [DEPTH-1:0] r_is2;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_occ;

    logic [31:0]      w_s_pc   [SLOTS];
    logic [31:0]      w_s_inst [SLOTS];
    logic [SLOTS-1:0] w_s_ex;
    logic [SLOTS-1:0] w_s_is2;
    int unsigned      w_push_total;
    logic [PW:0]      w_push_cnt;
    logic [PW:0]      w_pop_cnt;
    logic [PW:0]      w_free;
    logic             w_push;
    logic             w_pop;

    assign w_free    = (PW+1)'(DEPTH) - r_occ;
    assign in_ready  = (w_free >= (PW+1)'(SLOTS));
    assign occupancy = r_occ;
    assign w_push    = in_ready && (|in_valid);
    assign w_pop     = out_ready && (|out_valid);

    // Compaction: each valid lane claims one or two slots starting at the running
    // prefix sum of earlier lanes, so slot selection needs no variable indexing.
    always_comb begin
        int unsigned base;
        logic        two;
        base = 0;
        two  = 1'b0;
        w_s_ex  = '0;
        w_s_is2 = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            w_s_pc[s]   = '0;
            w_s_inst[s] = '0;
        end
        for (int unsigned l = 0; l < IN_WIDTH; l++) begin
            two = !in_ex[l] && is_two_uop(in_inst[l*32+26 +: 6], in_inst[l*32 +: 6]);
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (in_valid[l] && (s == base || (two && s == base + 1))) begin
                    w_s_pc[s]   = in_pc[l*32 +: 32];
                    w_s_inst[s] = in_inst[l*32 +: 32];
                    w_s_ex[s]   = in_ex[l];
                    w_s_is2[s]  = (s != base);
                end
            end
            if (in_valid[l]) begin
                base = base + (two ? 2 : 1);
            end
        end
        w_push_total = base;
        w_push_cnt   = (PW+1)'(base);
    end

    // A first uop may not occupy the last lane; the group ends before it.
    always_comb begin
        logic [PW-1:0] idx;
        logic          stop;
        logic          first;
        int unsigned   cnt;
        idx          = '0;
        stop         = 1'b0;
        first        = 1'b0;
        cnt          = 0;
        out_valid    = '0;
        out_pc       = '0;
        out_inst     = '0;
        out_ex       = '0;
        out_is_inst2 = '0;
        for (int unsigned l = 0; l < OUT_WIDTH; l++) begin
            idx   = r_head + PW'(l);
            first = !r_is2[idx] && !r_ex[idx] && is_two_uop(r_inst[idx][31:26], r_inst[idx][5:0]);
            if (stop || ((PW+1)'(l) >= r_occ) || (l == unsigned'(OUT_WIDTH - 1) && first)) begin
                stop = 1'b1;
            end else begin
                out_valid[l]          = 1'b1;
                out_pc[l*32 +: 32]    = r_pc[idx];
                out_inst[l*32 +: 32]  = r_inst[idx];
                out_ex[l]             = r_ex[idx];
                out_is_inst2[l]       = r_is2[idx];
                cnt                   = cnt + 1;
            end
        end
        w_pop_cnt = (PW+1)'(cnt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + w_push_cnt[PW-1:0];
            end
            if (w_pop) begin
                r_head <= r_head + w_pop_cnt[PW-1:0];
            end
            r_occ <= r_occ + (w_push ? w_push_cnt : '0) - (w_pop ? w_pop_cnt : '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (resetn && w_push && !flush && s < w_push_total) begin
                r_pc[r_tail + PW'(s)]   <= w_s_pc[s];
                r_inst[r_tail + PW'(s)] <= w_s_inst[s];
                r_ex[r_tail + PW'(s)]   <= w_s_ex[s];
                r_is2[r_tail + PW'(s)]  <= w_s_is2[s];
            end
        end
    end

endmodule
